player_bullet_pool: RTL and testbench

- Fixed pool of player bullets; spawns on fire, moves all live bullets upward once per frame, retires bullets that leave the top of the screen or are reported hit.
- Sits directly upstream of the enemy hit-detection stage: drives its bullet_x/bullet_y/bullet_active arrays and consumes its bullet_hit array.
- All state is in the clk25 domain.

---
 rtl/player_bullet_pool_if.sv | 25 ++
 rtl/player_bullet_pool.sv | 151 +++++++++++++++
 tb/tb_player_bullet_pool.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/player_bullet_pool_if.sv
// rtl/player_bullet_pool_if.sv - bullet slot bus between the bullet pool and enemy hit detection
interface player_bullet_pool_if #(
  parameter int BULLET_COUNT = 8
);
  logic [9:0] bullet_x      [0:BULLET_COUNT-1];
  logic [9:0] bullet_y      [0:BULLET_COUNT-1];
  logic       bullet_active [0:BULLET_COUNT-1];
  logic       bullet_hit    [0:BULLET_COUNT-1];

  // bullet pool side
  modport master (
    output bullet_x,
    output bullet_y,
    output bullet_active,
    input  bullet_hit
  );

  // hit-detection side
  modport slave (
    input  bullet_x,
    input  bullet_y,
    input  bullet_active,
    output bullet_hit
  );
endinterface

// File: rtl/player_bullet_pool.sv
// rtl/player_bullet_pool.sv - fixed pool of player bullets: spawn on fire, move up per frame, retire on exit or hit (option: BULLET_AUTOFIRE_EN)
module player_bullet_pool #(
  parameter int BULLET_COUNT    = 8,
  parameter int BULLET_SPEED    = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int SPAWN_X_OFS     = 14
) (
  input  logic                 clk25,
  input  logic                 reset_n,
  input  logic                 frame_tick,
  input  logic                 game_enable,
  input  logic                 fire,
  input  logic [9:0]           player_x,
  input  logic [9:0]           player_y,
  player_bullet_pool_if.master bus,
  output logic                 fire_accepted,
  output logic                 pool_full
);

  localparam int IDX_W = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;
  localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    fire_prev;
  logic [CD_W-1:0]         cooldown;
  logic [9:0]              x_q [0:BULLET_COUNT-1];
  logic [9:0]              y_q [0:BULLET_COUNT-1];
  logic [BULLET_COUNT-1:0] active_q;
  logic [BULLET_COUNT-1:0] hit;
  logic                    fire_rise;
  logic                    cd_zero;
  logic                    service;
  logic                    spawn;
  logic                    free_found;
  logic [IDX_W-1:0]        free_idx;

  assign fire_rise = fire & ~fire_prev;
  assign cd_zero   = (cooldown == '0);
  assign pool_full = &active_q;

  for (genvar g = 0; g < BULLET_COUNT; g++) begin : g_bus
    assign hit[g]                = bus.bullet_hit[g];
    assign bus.bullet_x[g]      = x_q[g];
    assign bus.bullet_y[g]      = y_q[g];
    assign bus.bullet_active[g] = active_q[g];
  end

  // Lowest-index inactive slot; a slot being hit this cycle still counts as active.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int j = BULLET_COUNT - 1; j >= 0; j--) begin
      if (!active_q[j]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(j);
      end
    end
  end

  // Fire FSM state register.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Fire FSM next state: arm on fire, resolve the buffered shot on a frame tick once cooldown expires.
  always_comb begin
    state_d = state_q;
    if (!game_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
`ifdef BULLET_AUTOFIRE_EN
          if (fire_rise || (fire && frame_tick)) state_d = PENDING;
`else
          if (fire_rise) state_d = PENDING;
`endif
        end
        PENDING: begin
          if (frame_tick && cd_zero) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Fire FSM outputs: a serviced shot spawns only when cooldown is over and a slot is free.
  always_comb begin
    service = 1'b0;
    spawn   = 1'b0;
    if (game_enable && state_q == PENDING && frame_tick) begin
      service = 1'b1;
      spawn   = cd_zero & free_found;
    end
  end

  // Fire level history for edge detection.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) fire_prev <= 1'b0;
    else          fire_prev <= fire;
  end

  // Cooldown: loaded on spawn, counts frames down to zero otherwise.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n)                     cooldown <= '0;
    else if (!game_enable)            cooldown <= '0;
    else if (spawn)                   cooldown <= CD_W'(COOLDOWN_FRAMES);
    else if (frame_tick && !cd_zero)  cooldown <= cooldown - CD_W'(1);
  end

  // One-cycle acknowledge of a spawned bullet.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) fire_accepted <= 1'b0;
    else          fire_accepted <= spawn;
  end

  // Slot update: hit beats movement; the freshly spawned slot was inactive so it is not moved this tick.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= '0;
      for (int j = 0; j < BULLET_COUNT; j++) begin
        x_q[j] <= '0;
        y_q[j] <= '0;
      end
    end else if (!game_enable) begin
      active_q <= '0;
    end else begin
      for (int j = 0; j < BULLET_COUNT; j++) begin
        if (hit[j] && active_q[j]) begin
          active_q[j] <= 1'b0;
        end else if (spawn && free_idx == IDX_W'(j)) begin
          x_q[j]      <= player_x + 10'(SPAWN_X_OFS);
          y_q[j]      <= player_y;
          active_q[j] <= 1'b1;
        end else if (frame_tick && active_q[j]) begin
          if (y_q[j] < 10'(BULLET_SPEED)) active_q[j] <= 1'b0;
          else                            y_q[j]      <= y_q[j] - 10'(BULLET_SPEED);
        end
      end
    end
  end

  // service is only consumed through spawn and the FSM; keep it visible for debug probing.
  logic unused_ok;
  assign unused_ok = service;

endmodule

// File: tb/tb_player_bullet_pool.sv
// tb/tb_player_bullet_pool.sv - directed self-checking bench for player_bullet_pool
module tb_player_bullet_pool;

  logic       clk25;
  logic       reset_n;
  logic       frame_tick;
  logic       game_enable;
  logic       fire;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       fire_accepted;
  logic       pool_full;

  int n_cmp;
  int n_bad;

  player_bullet_pool_if #(.BULLET_COUNT(8)) bus ();

  player_bullet_pool #(
    .BULLET_COUNT(8), .BULLET_SPEED(4), .COOLDOWN_FRAMES(8), .SPAWN_X_OFS(14)
  ) dut (
    .clk25        (clk25),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .game_enable  (game_enable),
    .fire         (fire),
    .player_x     (player_x),
    .player_y     (player_y),
    .bus          (bus.master),
    .fire_accepted(fire_accepted),
    .pool_full    (pool_full)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk25);
      #1;
    end
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic fire_edge();
    fire = 1'b1;
    step(1);
    fire = 1'b0;
    step(1);
  endtask

  task automatic clear_pool();
    game_enable = 1'b0;
    step(1);
    game_enable = 1'b1;
  endtask

  task automatic shoot(input string tag);
    bit got;
    got = 1'b0;
    fire_edge();
    for (int i = 0; i < 12 && !got; i++) begin
      frame();
      if (fire_accepted) got = 1'b1;
    end
    check(tag, 32'(got), 32'd1);
  endtask

  task automatic count_accepts(input int frames, output int acc);
    acc = 0;
    for (int i = 0; i < frames; i++) begin
      frame();
      if (fire_accepted) acc++;
    end
  endtask

  initial begin
    int acc;
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    frame_tick = 1'b0;
    game_enable = 1'b0;
    fire = 1'b0;
    player_x = 10'd100;
    player_y = 10'd400;
    for (int j = 0; j < 8; j++) bus.bullet_hit[j] = 1'b0;

    // reset state
    step(2);
    check("rst_active0", 32'(bus.bullet_active[0]), 32'd0);
    check("rst_x0", 32'(bus.bullet_x[0]), 32'd0);
    check("rst_y7", 32'(bus.bullet_y[7]), 32'd0);
    check("rst_accept", 32'(fire_accepted), 32'd0);
    check("rst_full", 32'(pool_full), 32'd0);
    reset_n = 1'b1;
    game_enable = 1'b1;
    step(1);

    // spawn: frame 0
    fire_edge();
    check("no_spawn_wo_tick", 32'(bus.bullet_active[0]), 32'd0);
    frame();
    check("spawn_active0", 32'(bus.bullet_active[0]), 32'd1);
    check("spawn_x0", 32'(bus.bullet_x[0]), 32'd114);
    check("spawn_y0", 32'(bus.bullet_y[0]), 32'd400);
    check("spawn_accept", 32'(fire_accepted), 32'd1);
    step(1);
    check("accept_pulse", 32'(fire_accepted), 32'd0);

    // cooldown buffering: edge before frame 2, spawn at frame 9
    frame();
    fire_edge();
    frame();
    fire_edge();
    count_accepts(6, acc);
    check("cd_no_early", 32'(acc), 32'd0);
    frame();
    check("cd_spawn_f9", 32'(fire_accepted), 32'd1);
    check("cd_slot1", 32'(bus.bullet_active[1]), 32'd1);
    check("cd_y0_moved", 32'(bus.bullet_y[0]), 32'd364);
    check("cd_y1", 32'(bus.bullet_y[1]), 32'd400);
    count_accepts(10, acc);
    check("cd_extra_ignored", 32'(acc), 32'd0);
    check("cd_y1_f19", 32'(bus.bullet_y[1]), 32'd360);

    // game_enable drop clears active, holds position
    game_enable = 1'b0;
    step(1);
    check("ge_active0", 32'(bus.bullet_active[0]), 32'd0);
    check("ge_active1", 32'(bus.bullet_active[1]), 32'd0);
    check("ge_y0_hold", 32'(bus.bullet_y[0]), 32'd324);
    check("ge_x1_hold", 32'(bus.bullet_x[1]), 32'd114);
    game_enable = 1'b1;

    // move and retire without wrap
    player_y = 10'd6;
    shoot("mv_shoot");
    check("mv_y_start", 32'(bus.bullet_y[0]), 32'd6);
    frame();
    check("mv_y2", 32'(bus.bullet_y[0]), 32'd2);
    check("mv_alive", 32'(bus.bullet_active[0]), 32'd1);
    frame();
    check("mv_retired", 32'(bus.bullet_active[0]), 32'd0);
    check("mv_no_wrap", 32'(bus.bullet_y[0]), 32'd2);

    // hit with simultaneous pending spawn
    clear_pool();
    player_y = 10'd900;
    player_x = 10'd1015;
    shoot("hit_s0");
    check("x_trunc", 32'(bus.bullet_x[0]), 32'd5);
    player_x = 10'd100;
    shoot("hit_s1");
    shoot("hit_s2");
    shoot("hit_s3");
    count_accepts(9, acc);
    fire_edge();
    bus.bullet_hit[3] = 1'b1;
    frame();
    bus.bullet_hit[3] = 1'b0;
    check("hit_slot3_off", 32'(bus.bullet_active[3]), 32'd0);
    check("hit_spawn4", 32'(bus.bullet_active[4]), 32'd1);
    check("hit_accept", 32'(fire_accepted), 32'd1);
    check("hit_slot2_on", 32'(bus.bullet_active[2]), 32'd1);
    bus.bullet_hit[7] = 1'b1;
    step(1);
    bus.bullet_hit[7] = 1'b0;
    check("hit_inactive", 32'(bus.bullet_active[7]), 32'd0);

    // fill the pool: slot 3 refilled first, then 5..7
    shoot("full_s3");
    check("refill_slot3", 32'(bus.bullet_active[3]), 32'd1);
    check("refill_not5", 32'(bus.bullet_active[5]), 32'd0);
    shoot("full_s5");
    shoot("full_s6");
    check("not_full_yet", 32'(pool_full), 32'd0);
    shoot("full_s7");
    check("pool_full", 32'(pool_full), 32'd1);
    count_accepts(9, acc);
    fire_edge();
    frame();
    check("full_no_accept", 32'(fire_accepted), 32'd0);
    check("full_still", 32'(pool_full), 32'd1);
    bus.bullet_hit[0] = 1'b1;
    step(1);
    bus.bullet_hit[0] = 1'b0;
    check("full_hit0", 32'(bus.bullet_active[0]), 32'd0);
    check("full_cleared", 32'(pool_full), 32'd0);
    count_accepts(2, acc);
    check("dropped_shot", 32'(acc), 32'd0);
    check("slot0_free", 32'(bus.bullet_active[0]), 32'd0);

    // asynchronous reset mid-flight
    clear_pool();
    for (int k = 0; k < 5; k++) shoot("rm_shoot");
    check("rm_pre_active4", 32'(bus.bullet_active[4]), 32'd1);
    check("rm_pre_accept", 32'(fire_accepted), 32'd1);
    #5 reset_n = 1'b0;
    #2;
    check("rm_active0", 32'(bus.bullet_active[0]), 32'd0);
    check("rm_active4", 32'(bus.bullet_active[4]), 32'd0);
    check("rm_x0", 32'(bus.bullet_x[0]), 32'd0);
    check("rm_y4", 32'(bus.bullet_y[4]), 32'd0);
    check("rm_accept", 32'(fire_accepted), 32'd0);
    step(1);
    reset_n = 1'b1;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
